// File: rtl/octree_mmio_ctrl.sv
// Memory-mapped control front end for the Octree accelerator: CSR file,
// op sequencer with timeout, and host gating of the in_out/local SRAM windows.
//
// Handshakes: mem_req_i is a one-cycle strobe with no backpressure; every
// request is accepted on the edge that samples it and read data appears on
// mem_rdata_o exactly one cycle later (0 for writes, idle cycles and refused
// accesses). Toward the Octree, csr_ctrl_o holds the op until csr_op_done_i
// echoes that op (or the timeout expires), then drops to 0 and the Octree
// must return csr_op_done_i to 0 before the next op can start.
module octree_mmio_ctrl #(
  parameter int ENC_W   = 14,
  parameter int LOD_NUM = 5,
  parameter int TIMEOUT = 4096
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   mem_req_i,
  input  logic                   mem_write_en_i,
  input  logic [7:0]             mem_byte_en_i,
  input  logic [63:0]            mem_addr_i,
  input  logic [63:0]            mem_wdata_i,
  output logic [63:0]            mem_rdata_o,
  output logic                   irq_o,
  output logic [1:0]             csr_ctrl_o,
  input  logic [1:0]             csr_op_done_i,
  output logic [ENC_W-1:0]       csr_pos_encode_o,
  output logic [3:0]             csr_tree_num_o,
  output logic [LOD_NUM*16-1:0]  csr_lod_param_o,
  output logic                   csr_local_sram_en_o,
  output logic                   csr_in_out_sram_en_o,
  output logic                   io_req_o,
  output logic                   io_we_o,
  output logic [63:0]            io_addr_o,
  output logic [63:0]            io_wdata_o,
  input  logic [63:0]            io_rdata_i,
  output logic                   lc_req_o,
  output logic                   lc_we_o,
  output logic [63:0]            lc_addr_o,
  output logic [63:0]            lc_wdata_o,
  input  logic [63:0]            lc_rdata_i,
  output logic [1:0]             dbg_state_o
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_BUSY, S_CLEAR} state_t;
  typedef enum logic [1:0] {RD_NONE, RD_CSR, RD_IO, RD_LC} rd_sel_t;

  state_t             state_q;
  rd_sel_t            rd_sel_q;
  logic [1:0]         op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         done_q;
  logic               doneflag_q, timeout_q, err_q, sram_en_q;
  logic [ENC_W-1:0]   pos_q;
  logic [3:0]         tree_q;
  logic [15:0]        lod_q [LOD_NUM];
  logic [63:0]        csr_rd, csr_rd_q;

  // Address bits outside the decoded window are don't-care.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_addr_i[63:16], mem_addr_i[2:0]};

  logic [3:0] region;
  logic [8:0] csr_idx;
  logic       is_csr, is_io, is_lc, is_unmapped, idle;
  logic       csr_wr, ctrl_wr, launch, done_hit, to_hit, err_set;
  logic [2:0] st_w1c;  // {doneflag, err, timeout}

  assign region      = mem_addr_i[15:12];
  assign csr_idx     = mem_addr_i[11:3];
  assign is_csr      = (region == 4'd0);
  assign is_io       = (region == 4'd1);
  assign is_lc       = (region == 4'd2);
  assign is_unmapped = !(is_csr || is_io || is_lc);
  assign idle        = (state_q == S_IDLE);
  assign csr_wr      = mem_req_i && mem_write_en_i && is_csr;
  assign ctrl_wr     = csr_wr && (csr_idx == 9'd0) && mem_byte_en_i[0];
  assign launch      = idle && ctrl_wr && (mem_wdata_i[1:0] != 2'd0);
  assign st_w1c      = (csr_wr && csr_idx == 9'd1 && mem_byte_en_i[0]) ? mem_wdata_i[5:3] : 3'b000;
  assign done_hit    = (state_q == S_BUSY) && (csr_op_done_i == op_q);
  assign to_hit      = (state_q == S_BUSY) && !done_hit && (cnt_q == CNT_W'(TIMEOUT - 1));
  assign err_set     = mem_req_i && ((ctrl_wr && !idle) || ((is_io || is_lc) && !sram_en_q) || is_unmapped);

  function automatic logic [63:0] be_merge(input logic [63:0] old, input logic [63:0] wd,
                                           input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Op sequencer: launch, wait for matching done code or timeout, wait for done to drop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      csr_ctrl_o <= 2'd0;
      sram_en_q  <= 1'b1;
      op_q       <= 2'd0;
      cnt_q      <= '0;
      done_q     <= 2'd0;
      doneflag_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      doneflag_q <= done_hit || (doneflag_q && !st_w1c[2] && !launch);
      timeout_q  <= to_hit   || (timeout_q  && !st_w1c[0] && !launch);
      case (state_q)
        S_IDLE: if (launch) begin
          state_q    <= S_LAUNCH;
          op_q       <= mem_wdata_i[1:0];
          csr_ctrl_o <= mem_wdata_i[1:0];
          sram_en_q  <= 1'b0;
        end
        S_LAUNCH: begin
          state_q <= S_BUSY;
          cnt_q   <= '0;
        end
        S_BUSY: begin
          if (done_hit) begin
            state_q    <= S_CLEAR;
            csr_ctrl_o <= 2'd0;
            done_q     <= csr_op_done_i;
          end else if (to_hit) begin
            state_q    <= S_CLEAR;
            csr_ctrl_o <= 2'd0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: if (csr_op_done_i == 2'd0) begin
          state_q   <= S_IDLE;
          sram_en_q <= 1'b1;
        end
      endcase
    end
  end

  // Sticky error flag; a new error in the same cycle as its W1C wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_set || (err_q && !st_w1c[1]);
  end

  // Configuration registers, byte-enabled writes, writable regardless of state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pos_q  <= '0;
      tree_q <= 4'd0;
      for (int i = 0; i < LOD_NUM; i++) lod_q[i] <= 16'd0;
    end else if (csr_wr) begin
      if (csr_idx == 9'd2) pos_q  <= ENC_W'(be_merge(64'(pos_q), mem_wdata_i, mem_byte_en_i));
      if (csr_idx == 9'd3) tree_q <= 4'(be_merge({60'd0, tree_q}, mem_wdata_i, mem_byte_en_i));
      for (int i = 0; i < LOD_NUM; i++)
        if (csr_idx == 9'(4 + i)) lod_q[i] <= 16'(be_merge({48'd0, lod_q[i]}, mem_wdata_i, mem_byte_en_i));
    end
  end

  // CSR read value for the addressed register.
  always_comb begin
    csr_rd = 64'd0;
    case (csr_idx)
      9'd1: csr_rd = {58'd0, doneflag_q, err_q, timeout_q, !idle, done_q};
      9'd2: csr_rd = 64'(pos_q);
      9'd3: csr_rd = {60'd0, tree_q};
      default:
        for (int i = 0; i < LOD_NUM; i++)
          if (csr_idx == 9'(4 + i)) csr_rd = {48'd0, lod_q[i]};
    endcase
  end

  // Read pipeline: remember which source answers next cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_sel_q <= RD_NONE;
      csr_rd_q <= 64'd0;
    end else if (mem_req_i && !mem_write_en_i) begin
      csr_rd_q <= csr_rd;
      if (is_csr)                 rd_sel_q <= RD_CSR;
      else if (is_io && sram_en_q) rd_sel_q <= RD_IO;
      else if (is_lc && sram_en_q) rd_sel_q <= RD_LC;
      else                        rd_sel_q <= RD_NONE;
    end else begin
      rd_sel_q <= RD_NONE;
    end
  end

  // Read data mux and live outputs.
  always_comb begin
    mem_rdata_o = 64'd0;
    case (rd_sel_q)
      RD_CSR:  mem_rdata_o = csr_rd_q;
      RD_IO:   mem_rdata_o = io_rdata_i;
      RD_LC:   mem_rdata_o = lc_rdata_i;
      default: mem_rdata_o = 64'd0;
    endcase
    csr_lod_param_o = '0;
    for (int i = 0; i < LOD_NUM; i++) csr_lod_param_o[i*16 +: 16] = lod_q[i];
  end

  assign irq_o                = doneflag_q || timeout_q;
  assign csr_pos_encode_o     = pos_q;
  assign csr_tree_num_o       = tree_q;
  assign csr_local_sram_en_o  = sram_en_q;
  assign csr_in_out_sram_en_o = sram_en_q;
  assign dbg_state_o          = state_q;

  // SRAM windows: forwarded in the request cycle only while the host owns them.
  assign io_req_o   = mem_req_i && is_io && sram_en_q;
  assign io_we_o    = io_req_o && mem_write_en_i;
  assign io_addr_o  = {55'd0, csr_idx};
  assign io_wdata_o = mem_wdata_i;
  assign lc_req_o   = mem_req_i && is_lc && sram_en_q;
  assign lc_we_o    = lc_req_o && mem_write_en_i;
  assign lc_addr_o  = {55'd0, csr_idx};
  assign lc_wdata_o = mem_wdata_i;

endmodule

// File: tb/tb_octree_mmio_ctrl.sv
// Bench for octree_mmio_ctrl: bus driver tasks, an Octree responder, SRAM
// models, and a per-cycle expectation queue for the sequencer-visible outputs.
module tb_octree_mmio_ctrl;
  localparam int ENC_W   = 14;
  localparam int LOD_NUM = 5;
  localparam int TIMEOUT = 16;

  logic                  clk_i = 1'b0, rst_i = 1'b1;
  logic                  mem_req_i = 1'b0, mem_write_en_i = 1'b0;
  logic [7:0]            mem_byte_en_i = 8'h0;
  logic [63:0]           mem_addr_i = 64'h0, mem_wdata_i = 64'h0;
  logic [63:0]           mem_rdata_o;
  logic                  irq_o;
  logic [1:0]            csr_ctrl_o;
  logic [1:0]            csr_op_done_i = 2'd0;
  logic [ENC_W-1:0]      csr_pos_encode_o;
  logic [3:0]            csr_tree_num_o;
  logic [LOD_NUM*16-1:0] csr_lod_param_o;
  logic                  csr_local_sram_en_o, csr_in_out_sram_en_o;
  logic                  io_req_o, io_we_o, lc_req_o, lc_we_o;
  logic [63:0]           io_addr_o, io_wdata_o, lc_addr_o, lc_wdata_o;
  logic [63:0]           io_rdata_i = 64'h0, lc_rdata_i = 64'h0;
  logic [1:0]            dbg_state_o;

  octree_mmio_ctrl #(.ENC_W(ENC_W), .LOD_NUM(LOD_NUM), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .mem_req_i(mem_req_i), .mem_write_en_i(mem_write_en_i),
    .mem_byte_en_i(mem_byte_en_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o), .irq_o(irq_o), .csr_ctrl_o(csr_ctrl_o),
    .csr_op_done_i(csr_op_done_i), .csr_pos_encode_o(csr_pos_encode_o),
    .csr_tree_num_o(csr_tree_num_o), .csr_lod_param_o(csr_lod_param_o),
    .csr_local_sram_en_o(csr_local_sram_en_o), .csr_in_out_sram_en_o(csr_in_out_sram_en_o),
    .io_req_o(io_req_o), .io_we_o(io_we_o), .io_addr_o(io_addr_o), .io_wdata_o(io_wdata_o),
    .io_rdata_i(io_rdata_i), .lc_req_o(lc_req_o), .lc_we_o(lc_we_o), .lc_addr_o(lc_addr_o),
    .lc_wdata_o(lc_wdata_o), .lc_rdata_i(lc_rdata_i), .dbg_state_o(dbg_state_o)
  );

  // Clock and watchdog
  always #5 clk_i = ~clk_i;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int n_vec = 0;
  int n_err = 0;

  // Expected {ctrl[1:0], sram_en, irq} for each cycle of an op in flight.
  logic [3:0] exp_q[$];
  bit         m_doneflag = 0, m_timeout = 0, m_err = 0;
  logic [1:0] m_done = 2'd0;
  bit         rd_pending = 0;

  int         oct_delay = 10;
  bit         oct_never = 0;
  int         oct_cnt = 0;
  int         last_ctrl_len = 0;
  logic [1:0] ops_q[$];

  logic [63:0] io_mem [0:511];
  logic [63:0] lc_mem [0:511];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] status_exp();
    return {58'd0, m_doneflag, m_err, m_timeout, exp_q.size() != 0, m_done};
  endfunction

  // Octree responder: echoes the op once it has been held for oct_delay cycles.
  always @(negedge clk_i) begin
    if (csr_ctrl_o != 2'd0) begin
      if (oct_cnt == 0) ops_q.push_back(csr_ctrl_o);
      oct_cnt++;
      if (!oct_never && oct_cnt > oct_delay) csr_op_done_i = csr_ctrl_o;
    end else begin
      if (oct_cnt > 0) last_ctrl_len = oct_cnt;
      oct_cnt = 0;
      csr_op_done_i = 2'd0;
    end
  end

  // Synchronous-read SRAM models behind the two windows.
  always @(posedge clk_i) begin
    if (io_req_o) begin
      if (io_we_o) io_mem[io_addr_o[8:0]] <= io_wdata_o;
      else         io_rdata_i <= io_mem[io_addr_o[8:0]];
    end
    if (lc_req_o) begin
      if (lc_we_o) lc_mem[lc_addr_o[8:0]] <= lc_wdata_o;
      else         lc_rdata_i <= lc_mem[lc_addr_o[8:0]];
    end
  end

  // Per-cycle compare of sequencer outputs, and of idle read data.
  always @(negedge clk_i) begin
    logic [3:0] e;
    if (!rst_i) begin
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else                   e = {2'd0, 1'b1, m_doneflag | m_timeout};
      check("cycle_outputs", {59'd0, csr_ctrl_o, csr_local_sram_en_o, csr_in_out_sram_en_o, irq_o},
            {59'd0, e[3:2], e[1], e[1], e[0]});
      if (!rd_pending) check("rdata_idle", mem_rdata_o, 64'd0);
    end
  end

  // Driver: one write cycle; entered and left 2 time units after a posedge.
  task automatic bus_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] be);
    logic [3:0] region;
    logic [8:0] idx;
    bit         idle, launch;
    int         clen;
    region = addr[15:12];
    idx    = addr[11:3];
    idle   = (exp_q.size() == 0);
    launch = idle && region == 4'd0 && idx == 9'd0 && be[0] && data[1:0] != 2'd0;
    mem_req_i = 1'b1; mem_write_en_i = 1'b1; mem_addr_i = addr; mem_wdata_i = data; mem_byte_en_i = be;
    #1;
    if (region == 4'd1) begin
      check("io_wr_req", {62'd0, io_req_o, io_we_o}, {62'd0, idle, idle});
      if (idle) check("io_wr_addr", io_addr_o, {55'd0, idx});
      if (idle) check("io_wr_data", io_wdata_o, data);
    end
    if (region == 4'd2) begin
      check("lc_wr_req", {62'd0, lc_req_o, lc_we_o}, {62'd0, idle, idle});
      if (idle) check("lc_wr_addr", lc_addr_o, {55'd0, idx});
      if (idle) check("lc_wr_data", lc_wdata_o, data);
    end
    @(posedge clk_i); #2;
    mem_req_i = 1'b0; mem_write_en_i = 1'b0;
    if (region > 4'd2 || ((region == 4'd1 || region == 4'd2) && !idle) ||
        (region == 4'd0 && idx == 9'd0 && be[0] && !idle)) m_err = 1;
    if (region == 4'd0 && idx == 9'd1 && be[0]) begin
      if (data[3]) m_timeout = 0;
      if (data[4]) m_err = 0;
      if (data[5]) m_doneflag = 0;
    end
    if (launch) begin
      clen = oct_never ? TIMEOUT + 1 : oct_delay + 1;
      for (int k = 1; k <= clen + 1; k++)
        exp_q.push_back({(k <= clen) ? data[1:0] : 2'd0, 1'b0, k > clen});
      m_doneflag = !oct_never;
      m_timeout  = oct_never;
      if (!oct_never) m_done = data[1:0];
    end
  endtask

  // Driver: one read cycle, checks data one cycle after the request.
  task automatic bus_read(input logic [63:0] addr, input logic [63:0] exp, input string name);
    logic [3:0] region;
    bit         idle;
    region = addr[15:12];
    idle   = (exp_q.size() == 0);
    rd_pending = 1;
    mem_req_i = 1'b1; mem_write_en_i = 1'b0; mem_addr_i = addr; mem_byte_en_i = 8'h0;
    #1;
    if (region == 4'd1) check("io_rd_req", {62'd0, io_req_o, io_we_o}, {62'd0, idle, 1'b0});
    if (region == 4'd2) check("lc_rd_req", {62'd0, lc_req_o, lc_we_o}, {62'd0, idle, 1'b0});
    @(posedge clk_i); #2;
    mem_req_i = 1'b0;
    if (region > 4'd2 || ((region == 4'd1 || region == 4'd2) && !idle)) m_err = 1;
    @(negedge clk_i);
    check(name, mem_rdata_o, exp);
    @(posedge clk_i); #2;
    rd_pending = 0;
  endtask

  task automatic wait_idle();
    while (exp_q.size() != 0) @(posedge clk_i);
    #2;
  endtask

  // Directed sequence
  initial begin
    repeat (3) @(negedge clk_i);
    check("rst_outputs", {59'd0, csr_ctrl_o, csr_local_sram_en_o, csr_in_out_sram_en_o, irq_o},
          {59'd0, 2'd0, 1'b1, 1'b1, 1'b0});
    check("rst_rdata", mem_rdata_o, 64'd0);
    check("rst_sram_req", {62'd0, io_req_o, lc_req_o}, 64'd0);
    @(posedge clk_i); #2;
    rst_i = 1'b0;

    check("model_status_reset", status_exp(), 64'h0);
    bus_read(64'h0008, 64'h0, "status_reset");

    bus_write(64'h0010, 64'h3ABC, 8'h03);
    bus_read(64'h0010, 64'h3ABC, "pos_be03");
    bus_write(64'h0010, 64'hFF, 8'h01);
    bus_read(64'h0010, 64'h3AFF, "pos_be01");
    bus_write(64'h0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'h02);
    bus_read(64'h0010, 64'h3FFF, "pos_unused_bits");
    check("pos_port", 64'(csr_pos_encode_o), 64'h3FFF);
    bus_write(64'h0018, 64'hA5, 8'hFF);
    bus_read(64'h0018, 64'h5, "tree_num");
    check("tree_port", 64'(csr_tree_num_o), 64'h5);
    bus_write(64'h0040, 64'h1234_5678, 8'h0F);
    bus_write(64'h0020, 64'hBEEF, 8'h02);
    bus_read(64'h0040, 64'h5678, "lod4");
    bus_read(64'h0020, 64'hBE00, "lod0");
    check("lod_port", {32'd0, csr_lod_param_o[79:64], csr_lod_param_o[15:0]}, 64'h5678_BE00);
    bus_read(64'h0000, 64'h0, "ctrl_reads_zero");

    // Search op answered after 10 cycles
    oct_delay = 10; oct_never = 0;
    bus_write(64'h0000, 64'h1, 8'hFF);
    wait_idle();
    check("ctrl_len_search", 64'(last_ctrl_len), 64'd11);
    check("model_status_search", status_exp(), 64'h21);
    bus_read(64'h0008, 64'h21, "status_search");
    bus_write(64'h0008, 64'h20, 8'h01);
    bus_read(64'h0008, 64'h01, "status_w1c_done");

    // Add op with a dropped delete issued while busy
    ops_q.delete();
    bus_write(64'h0000, 64'h2, 8'hFF);
    bus_write(64'h0000, 64'h3, 8'hFF);
    bus_read(64'h0008, 64'h15, "status_busy");
    wait_idle();
    check("ops_run", {32'd0, 32'(ops_q.size()), 30'd0, ops_q[0]}, {32'd0, 32'd1, 32'd2});
    check("ctrl_len_add", 64'(last_ctrl_len), 64'd11);
    bus_read(64'h0008, 64'h32, "status_add_err");
    bus_write(64'h0008, 64'h30, 8'h01);
    bus_read(64'h0008, status_exp(), "status_w1c_err");

    // Octree never answers: timeout
    oct_never = 1;
    bus_write(64'h0000, 64'h1, 8'hFF);
    wait_idle();
    oct_never = 0;
    check("ctrl_len_timeout", 64'(last_ctrl_len), 64'd17);
    check("irq_timeout", 64'(irq_o), 64'd1);
    bus_read(64'h0008, 64'h0A, "status_timeout");
    bus_write(64'h0008, 64'h08, 8'h01);
    bus_read(64'h0008, 64'h02, "status_w1c_timeout");

    // SRAM windows
    bus_write(64'h2008, 64'hDEAD, 8'hFF);
    bus_read(64'h2008, 64'hDEAD, "lc_read");
    bus_write(64'h1010, 64'hBEEF, 8'h01);
    bus_read(64'h1010, 64'hBEEF, "io_read_full_word");
    bus_write(64'h0000, 64'h1, 8'hFF);
    bus_write(64'h2008, 64'h1111, 8'hFF);
    bus_read(64'h2008, 64'h0, "lc_read_busy");
    wait_idle();
    bus_read(64'h0008, 64'h31, "status_sram_busy");
    bus_read(64'h2008, 64'hDEAD, "lc_after_busy");

    // Unmapped accesses
    bus_write(64'h0008, 64'h30, 8'h01);
    bus_read(64'h3000, 64'h0, "unmapped_read");
    bus_write(64'h0008, 64'h10, 8'h01);
    bus_write(64'h4000, 64'h55, 8'hFF);
    check("model_status_unmapped", status_exp(), 64'h11);
    bus_read(64'h0008, 64'h11, "status_unmapped");

    repeat (2) @(posedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
